fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register, located directly upstream of the hazard/control unit.
- Holds the PC and issues requests to instruction memory over a request/valid handshake.
- Consumes the hazard unit's PC_write, IF_write and addrSel outputs to stall, redirect or advance.
- Buffers an instruction that returns while IF/ID is stalled.
- Raises fetch_stall while a memory response is outstanding.

---
 rtl/fetch_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC and fetches from instruction memory over a req/valid
// handshake. The hazard unit stalls, advances or redirects the stage
// through PC_write, IF_write, IF_flush and addrSel. An instruction that
// returns while IF/ID is stalled is buffered (HELD state). fetch_stall is
// high while a response is outstanding (WAIT state).
//
// Ports:
//   Clk, Rst            clock (rising edge), synchronous active-low reset
//   PC_write, IF_write  hazard-unit enables for the PC and IF/ID
//   IF_flush            loads NOP_INSTR / 0 into IF/ID
//   addrSel             next-PC select: 00 PC+4, 01 Jump, 10 Branch, 11 Jr
//   JumpAddr, BranchAddr, JrAddr  redirect targets (bits [1:0] dropped)
//   imem_addr, imem_req instruction-memory request (address = PC)
//   imem_rdata, imem_valid        instruction-memory response
//   fetch_stall         response outstanding; PC and IF/ID frozen
//   ID_Instr, ID_PC4    IF/ID register contents
//
// Optional: define FETCH_PERF_EN to add saturating fetch_count and
// stall_count outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_write,
    input  logic        IF_write,
    input  logic        IF_flush,
    input  logic [1:0]  addrSel,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JrAddr,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        fetch_stall,
    output logic [31:0] ID_Instr,
    output logic [31:0] ID_PC4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HELD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        imem_req_q, imem_req_d;
    logic        fetch_stall_q, fetch_stall_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        wr_en;
    logic        id_load;

    assign pc_plus4  = pc_q + 32'd4;
    assign redirect  = PC_write && (addrSel != 2'b00);
    // Flush wins over IF_write; the PC/FSM then behave as if IF_write=0.
    assign wr_en     = IF_write && !IF_flush;

    always_comb begin
        next_pc = pc_plus4;
        case (addrSel)
            2'b01:   next_pc = {JumpAddr[31:2], 2'b00};
            2'b10:   next_pc = {BranchAddr[31:2], 2'b00};
            2'b11:   next_pc = {JrAddr[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        buf_d      = buf_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        id_load    = 1'b0;

        if (IF_flush) begin
            id_instr_d = NOP_INSTR;
            id_pc4_d   = '0;
        end

        case (state_q)
            // FETCH and WAIT share one path: pend_q is always clear in FETCH.
            S_FETCH, S_WAIT: begin
                if (imem_valid) begin
                    if (redirect || pend_q) begin
                        // Same-cycle redirect is newer than a pending one.
                        pc_d    = redirect ? next_pc : tgt_q;
                        pend_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        if (wr_en) begin
                            id_instr_d = imem_rdata;
                            id_pc4_d   = pc_plus4;
                            id_load    = 1'b1;
                        end else begin
                            buf_d = imem_rdata;
                        end
                        if (PC_write) begin
                            pc_d = pc_plus4;
                        end
                        state_d = (!wr_en && !PC_write) ? S_HELD : S_FETCH;
                    end
                end else begin
                    // Address must stay stable while waiting; remember redirects.
                    state_d = S_WAIT;
                    if (redirect) begin
                        pend_d = 1'b1;
                        tgt_d  = next_pc;
                    end
                end
            end
            S_HELD: begin
                if (redirect) begin
                    buf_d   = '0;
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end else if (wr_en) begin
                    id_instr_d = buf_q;
                    id_pc4_d   = pc_plus4;
                    id_load    = 1'b1;
                    if (PC_write) begin
                        pc_d = pc_plus4;
                    end
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        imem_req_d    = (state_d != S_HELD);
        fetch_stall_d = (state_d == S_WAIT);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc4_q      <= '0;
            buf_q         <= '0;
            pend_q        <= 1'b0;
            tgt_q         <= '0;
            imem_req_q    <= 1'b1;
            fetch_stall_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            buf_q         <= buf_d;
            pend_q        <= pend_d;
            tgt_q         <= tgt_d;
            imem_req_q    <= imem_req_d;
            fetch_stall_q <= fetch_stall_d;
        end
    end

    // Request/stall are forced low for as long as reset is held.
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q && Rst;
    assign fetch_stall = fetch_stall_q && Rst;
    assign ID_Instr    = id_instr_q;
    assign ID_PC4      = id_pc4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (id_load && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (fetch_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
